// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the CPU control slice.
// Holds the PC sequencer state encoding and branch-control bundle.
package cpu_ctrl_pkg;

    localparam int PC_W_DEF        = 32;
    localparam int OFFSET_W_DEF    = 8;
    localparam int INSTR_BYTES_DEF = 4;
    localparam int TAKEN_CNT_W     = 16;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic jump;
        logic beq;
        logic bne;
        logic zero;
    } br_ctrl_t;

    // Resolve the redirect decision; jump wins, beq+bne together is void
    function automatic logic br_redirect(input br_ctrl_t c);
        logic w_jmp;
        logic w_both;
        logic w_eq;
        logic w_ne;
        logic r;
        w_jmp  = c.jump;
        w_both = ~c.jump & c.beq & c.bne;
        w_eq   = ~c.jump & c.beq & ~c.bne;
        w_ne   = ~c.jump & ~c.beq & c.bne;
        r      = 1'b0;
        unique case (1'b1)
            w_jmp:   r = 1'b1;
            w_both:  r = 1'b0;
            w_eq:    r = c.zero;
            w_ne:    r = ~c.zero;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Next fetch address selection for the PC sequencer.
// Pure combinational: sequential, or PC-relative target on redirect.
module next_pc_calc
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int OFFSET_W    = OFFSET_W_DEF,
    parameter int INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  logic [PC_W-1:0]     i_pc,
    input  logic [OFFSET_W-1:0] i_offset,
    input  logic                i_jump,
    input  logic                i_branch_eq,
    input  logic                i_branch_ne,
    input  logic                i_zero,
    output logic [PC_W-1:0]     o_next_pc,
    output logic                o_redirect
);

    logic [PC_W-1:0] w_seq;
    logic [PC_W-1:0] w_off_ext;
    logic [PC_W-1:0] w_off_bytes;
    logic [PC_W-1:0] w_target;
    br_ctrl_t        w_ctrl;

    assign w_ctrl.jump = i_jump;
    assign w_ctrl.beq  = i_branch_eq;
    assign w_ctrl.bne  = i_branch_ne;
    assign w_ctrl.zero = i_zero;

    assign w_seq       = i_pc + PC_W'(INSTR_BYTES);
    assign w_off_ext   = {{(PC_W-OFFSET_W){i_offset[OFFSET_W-1]}}, i_offset};
    assign w_off_bytes = w_off_ext * PC_W'(INSTR_BYTES);
    assign w_target    = w_seq + w_off_bytes;

    // Pick target or sequential address from the resolved redirect
    always_comb begin
        o_redirect = br_redirect(w_ctrl);
        o_next_pc  = o_redirect ? w_target : w_seq;
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, run/stall FSM and taken-redirect tracking.
// Optional taken counter built only with PC_SEQ_STATS_EN defined.
module pc_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int              PC_W        = PC_W_DEF,
    parameter int              OFFSET_W    = OFFSET_W_DEF,
    parameter int              INSTR_BYTES = INSTR_BYTES_DEF,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   BUSYWAIT,
    input  logic                   JUMP,
    input  logic                   BRANCH_EQ,
    input  logic                   BRANCH_NE,
    input  logic                   ZERO,
    input  logic [OFFSET_W-1:0]    OFFSET,
    output logic [PC_W-1:0]        PC,
    output logic                   PC_VALID,
    output logic                   TAKEN,
    output logic [TAKEN_CNT_W-1:0] TAKEN_COUNT
);

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic            r_taken;
    logic [PC_W-1:0] w_next_pc;
    logic            w_redirect;
    logic            w_advance;
    logic            w_pc_valid;

    next_pc_calc #(
        .PC_W        (PC_W),
        .OFFSET_W    (OFFSET_W),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_calc (
        .i_pc        (r_pc),
        .i_offset    (OFFSET),
        .i_jump      (JUMP),
        .i_branch_eq (BRANCH_EQ),
        .i_branch_ne (BRANCH_NE),
        .i_zero      (ZERO),
        .o_next_pc   (w_next_pc),
        .o_redirect  (w_redirect)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_RST;
        else       r_state <= w_state_nxt;
    end

    // Next-state: leave reset, then toggle run/stall on busywait
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RST:   w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = BUSYWAIT ? S_STALL : S_RUN;
            S_STALL: w_state_nxt = BUSYWAIT ? S_STALL : S_RUN;
            default: w_state_nxt = S_RST;
        endcase
    end

    // Outputs: advance only when running or stalled and memory is free
    always_comb begin
        w_advance  = 1'b0;
        w_pc_valid = 1'b0;
        case (r_state)
            S_RUN: begin
                w_advance  = ~BUSYWAIT;
                w_pc_valid = 1'b1;
            end
            S_STALL: begin
                w_advance  = ~BUSYWAIT;
                w_pc_valid = 1'b1;
            end
            default: begin
                w_advance  = 1'b0;
                w_pc_valid = 1'b0;
            end
        endcase
    end

    // PC and taken flag load together on every committed advance
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pc    <= RESET_PC;
            r_taken <= 1'b0;
        end else if (r_state == S_RST) begin
            r_pc    <= RESET_PC;
            r_taken <= 1'b0;
        end else if (w_advance) begin
            r_pc    <= w_next_pc;
            r_taken <= w_redirect;
        end
    end

`ifdef PC_SEQ_STATS_EN
    logic [TAKEN_CNT_W-1:0] r_taken_cnt;

    // Saturating count of committed redirects
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_taken_cnt <= '0;
        end else if (w_advance && w_redirect && !(&r_taken_cnt)) begin
            r_taken_cnt <= r_taken_cnt + 1'b1;
        end
    end

    assign TAKEN_COUNT = r_taken_cnt;
`else
    assign TAKEN_COUNT = '0;
`endif

    assign PC       = r_pc;
    assign PC_VALID = w_pc_valid;
    assign TAKEN    = r_taken;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer.
// Expected outputs come from a behavioural model of the fetch rules.
module tb_pc_sequencer;

    logic        CLK;
    logic        RESET;
    logic        BUSYWAIT;
    logic        JUMP;
    logic        BRANCH_EQ;
    logic        BRANCH_NE;
    logic        ZERO;
    logic [7:0]  OFFSET;
    logic [31:0] PC;
    logic        PC_VALID;
    logic        TAKEN;
    logic [15:0] TAKEN_COUNT;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        taken;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc    = 32'd0;
    logic        m_valid = 1'b0;
    logic        m_taken = 1'b0;
    int          m_cnt   = 0;

    pc_sequencer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BUSYWAIT    (BUSYWAIT),
        .JUMP        (JUMP),
        .BRANCH_EQ   (BRANCH_EQ),
        .BRANCH_NE   (BRANCH_NE),
        .ZERO        (ZERO),
        .OFFSET      (OFFSET),
        .PC          (PC),
        .PC_VALID    (PC_VALID),
        .TAKEN       (TAKEN),
        .TAKEN_COUNT (TAKEN_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model: what the fetch address becomes after one edge
    task automatic model_edge(input bit rst, input bit busy, input bit j,
                              input bit eq, input bit ne, input bit z,
                              input logic [7:0] off);
        bit take;
        int soff;
        if (rst) begin
            m_pc    = 32'd0;
            m_valid = 1'b0;
            m_taken = 1'b0;
            m_cnt   = 0;
        end else if (!m_valid) begin
            m_valid = 1'b1;
            m_taken = 1'b0;
        end else if (!busy) begin
            if (j)             take = 1'b1;
            else if (eq && ne) take = 1'b0;
            else if (eq)       take = z;
            else if (ne)       take = !z;
            else               take = 1'b0;
            soff = int'($signed(off));
            if (take) m_pc = m_pc + 32'(4 + soff * 4);
            else      m_pc = m_pc + 32'd4;
            m_taken = take;
            if (take && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic step(input bit rst, input bit busy, input bit j,
                        input bit eq, input bit ne, input bit z,
                        input logic [7:0] off);
        exp_t e;
        RESET     = rst;
        BUSYWAIT  = busy;
        JUMP      = j;
        BRANCH_EQ = eq;
        BRANCH_NE = ne;
        ZERO      = z;
        OFFSET    = off;
        model_edge(rst, busy, j, eq, ne, z, off);
        e.pc    = m_pc;
        e.valid = m_valid;
        e.taken = m_taken;
`ifdef PC_SEQ_STATS_EN
        e.cnt   = 16'(m_cnt);
`else
        e.cnt   = 16'd0;
`endif
        exp_q.push_back(e);
        @(negedge CLK);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    // Monitor: compare one expected record after every rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (PC !== e.pc) begin
                    bad++;
                    $display("FAIL pc: got %h want %h at %0t", PC, e.pc, $time);
                end
                total++;
                if (PC_VALID !== e.valid) begin
                    bad++;
                    $display("FAIL pc_valid: got %b want %b at %0t",
                             PC_VALID, e.valid, $time);
                end
                total++;
                if (TAKEN !== e.taken) begin
                    bad++;
                    $display("FAIL taken: got %b want %b at %0t",
                             TAKEN, e.taken, $time);
                end
                total++;
                if (TAKEN_COUNT !== e.cnt) begin
                    bad++;
                    $display("FAIL taken_count: got %h want %h at %0t",
                             TAKEN_COUNT, e.cnt, $time);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b1;
        BUSYWAIT  = 1'b0;
        JUMP      = 1'b0;
        BRANCH_EQ = 1'b0;
        BRANCH_NE = 1'b0;
        ZERO      = 1'b0;
        OFFSET    = 8'h00;
        @(negedge CLK);

        // Reset then free run: 0, 0 (valid), 4, 8
        step(1, 0, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 0, 8'h00);
        idle();
        idle();
        idle();
        // bne taken at PC=8 -> 24
        step(0, 0, 0, 0, 1, 0, 8'd3);
        idle();
        step(1, 0, 0, 0, 0, 0, 8'h00);
        idle();
        idle();
        idle();
        // bne not taken at PC=8 -> 12
        step(0, 0, 0, 0, 1, 1, 8'd3);
        idle();
        idle();
        // beq back at PC=20 -> 16
        step(0, 0, 0, 1, 0, 1, 8'hFE);
        idle();
        // beq+bne illegal at PC=20 -> 24
        step(0, 0, 0, 1, 1, 1, 8'hFE);
        // jump back to 8, then stall 3 cycles with a pending jump
        step(0, 0, 1, 0, 0, 0, 8'hFB);
        step(0, 1, 1, 0, 0, 0, 8'd5);
        step(0, 1, 1, 0, 0, 0, 8'd5);
        step(0, 1, 1, 0, 0, 0, 8'd5);
        step(0, 0, 1, 0, 0, 0, 8'd5);
        idle();
        idle();
        // reset while stalled at PC=40
        step(0, 1, 0, 0, 0, 0, 8'h00);
        step(1, 1, 0, 0, 0, 0, 8'h00);
        idle();
        // wrap: 0 -> FFFFFFFC -> 0
        step(0, 0, 1, 0, 0, 0, 8'hFE);
        idle();
        // self-loop with OFFSET = -1
        step(0, 0, 1, 0, 0, 0, 8'hFF);
        // five taken jumps
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 8'h00);
        idle();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0),
                 ($urandom_range(3) == 0),
                 ($urandom_range(5) == 0),
                 ($urandom_range(2) == 0),
                 ($urandom_range(2) == 0),
                 1'($urandom_range(1)),
                 8'($urandom));
        end

`ifdef PC_SEQ_STATS_EN
        // drive the counter into saturation
        step(1, 0, 0, 0, 0, 0, 8'h00);
        idle();
        for (int i = 0; i < 65540; i++) step(0, 0, 1, 0, 0, 0, 8'h01);
`endif

        idle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
